vga_timing_gen: RTL and testbench

// - Consumes the 31.5 MHz pixel clock and lock flag from the PLL stage; produces 640x480@72Hz VGA raster timing.
// - Outputs: hsync, vsync, data-enable, pixel coordinates and frame/line strobes.
// - Sits between the clock divider PLL and the tetris renderer / VGA DAC pins.
// - Holds the raster idle until the PLL is locked and stable.

---
 rtl/vga_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@72Hz default) with PLL-lock gating and settle delay.
// Optional colour-bar test pattern on rgb when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int   H_ACTIVE      = 640,
    parameter int   H_FP          = 24,
    parameter int   H_SYNC        = 40,
    parameter int   H_BP          = 128,
    parameter int   V_ACTIVE      = 480,
    parameter int   V_FP          = 9,
    parameter int   V_SYNC        = 3,
    parameter int   V_BP          = 28,
    parameter logic SYNC_POL      = 1'b0,
    parameter int   SETTLE_CYCLES = 1024,
    parameter int   CNT_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running,
    output logic [11:0]      rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SET_W   = $clog2(SETTLE_CYCLES) + 1;

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic             running_q, running_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             locked_s, active_s, vis_s;

    assign locked_s = sync2_q;

    // Control FSM and raster counters.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        h_d      = h_q;
        v_d      = v_q;
        case (state_q)
            ST_WAIT: begin
                h_d      = {CNT_W{1'b0}};
                v_d      = {CNT_W{1'b0}};
                settle_d = {SET_W{1'b0}};
                if (locked_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                h_d = {CNT_W{1'b0}};
                v_d = {CNT_W{1'b0}};
                if (!locked_s) begin
                    state_d  = ST_WAIT;
                    settle_d = {SET_W{1'b0}};
                end else if (settle_q == SET_LAST) begin
                    state_d  = ST_RUN;
                    settle_d = {SET_W{1'b0}};
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_WAIT;
                    h_d     = {CNT_W{1'b0}};
                    v_d     = {CNT_W{1'b0}};
                end else if (h_q == H_LAST) begin
                    h_d = {CNT_W{1'b0}};
                    if (v_q == V_LAST) begin
                        v_d = {CNT_W{1'b0}};
                    end else begin
                        v_d = v_q + CNT_W'(1);
                    end
                end else begin
                    h_d = h_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_WAIT;
                settle_d = {SET_W{1'b0}};
                h_d      = {CNT_W{1'b0}};
                v_d      = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode; a lock loss forces reset values on the very next edge.
    always_comb begin
        active_s      = (state_q == ST_RUN) && locked_s;
        vis_s         = (h_q < H_VIS) && (v_q < V_VIS);
        running_d     = (state_d == ST_RUN);
        de_d          = active_s && vis_s;
        x_d           = active_s ? h_q : {CNT_W{1'b0}};
        y_d           = active_s ? v_q : {CNT_W{1'b0}};
        line_start_d  = active_s && (h_q == {CNT_W{1'b0}});
        frame_start_d = active_s && (h_q == {CNT_W{1'b0}}) && (v_q == {CNT_W{1'b0}});
        if (active_s && (h_q >= HS_BEG) && (h_q < HS_END)) begin
            hsync_d = SYNC_POL;
        end else begin
            hsync_d = ~SYNC_POL;
        end
        if (active_s && (v_q >= VS_BEG) && (v_q < VS_END)) begin
            vsync_d = SYNC_POL;
        end else begin
            vsync_d = ~SYNC_POL;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] bar_s;

    // Eight vertical bars; bit 2/1/0 of the bar index lights red/green/blue.
    always_comb begin
        bar_s = 3'(h_q / CNT_W'(H_ACTIVE / 8));
        if (active_s && vis_s) begin
            rgb_d = {{4{bar_s[2]}}, {4{bar_s[1]}}, {4{bar_s[0]}}};
        end else begin
            rgb_d = 12'h000;
        end
    end
`else
    assign rgb_d = 12'h000;
`endif

    // State, synchronizer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            state_q       <= ST_WAIT;
            settle_q      <= {SET_W{1'b0}};
            h_q           <= {CNT_W{1'b0}};
            v_q           <= {CNT_W{1'b0}};
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= {CNT_W{1'b0}};
            y_q           <= {CNT_W{1'b0}};
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
            rgb_q         <= 12'h000;
        end else begin
            sync1_q       <= locked;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            settle_q      <= settle_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen with a shortened vertical raster to keep runtime small.
// Honours VGA_TIMING_TEST_PATTERN_EN for the expected rgb values.
module tb_vga_timing_gen;

    localparam int HA = 640, HF = 24, HS = 40, HB = 128;
    localparam int VA = 12, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int SET = 16;
    localparam int W = 11;
    localparam logic [39:0] RESET_VEC = {1'b1, 1'b1, 38'd0};

    logic         clk = 1'b0;
    logic         rst, locked;
    logic         hsync, vsync, de, line_start, frame_start, running;
    logic [W-1:0] x, y;
    logic [11:0]  rgb;

    int n_cmp = 0;
    int n_bad = 0;
    int hm = 0;
    int vm = 0;
    logic [39:0] sb_q[$];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .SETTLE_CYCLES(SET), .CNT_W(W)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .running(running), .rgb(rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] model(input int h, input int v);
        logic       vis, hs_a, vs_a;
        logic [11:0] c;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        logic [2:0] k;
`endif
        vis  = (h < HA) && (v < VA);
        hs_a = (h >= HA + HF) && (h < HA + HF + HS);
        vs_a = (v >= VA + VF) && (v < VA + VF + VS);
        c    = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        k = 3'(h / (HA / 8));
        if (vis) c = {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
`endif
        return {~hs_a, ~vs_a, vis, (h == 0), (h == 0 && v == 0), 1'b1, W'(h), W'(v), c};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {hsync, vsync, de, line_start, frame_start, running, x, y, rgb};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_next();
        sb_q.push_back(model(hm, vm));
        if (hm == HT - 1) begin
            hm = 0;
            vm = (vm == VT - 1) ? 0 : vm + 1;
        end else begin
            hm = hm + 1;
        end
    endtask

    task automatic wait_running(output int cyc);
        cyc = 0;
        while (!running && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b1;
        @(negedge clk);
        repeat (5) tick();
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), RESET_VEC);
        end
    endtask

    task automatic test_startup();
        int cyc;
        rst = 1'b0;
        wait_running(cyc);
        n_cmp++;
        if (cyc !== SET + 3) begin
            n_bad++;
            $display("FAIL startup_latency: got %0d cycles want %0d", cyc, SET + 3);
        end
        n_cmp++;
        if (dut_vec() !== {1'b1, 1'b1, 3'b000, 1'b1, 34'd0}) begin
            n_bad++;
            $display("FAIL run_entry_outputs: got %h want %h", dut_vec(), {1'b1, 1'b1, 3'b000, 1'b1, 34'd0});
        end
    endtask

    task automatic test_frames();
        logic [39:0] exp, act;
        int hs_lo = 0, vs_lo = 0, de_hi = 0, fs_n = 0, fs_at = -1, fs_per = 0;
        hm = 0;
        vm = 0;
        sb_q.delete();
        push_next();
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick();
            exp = sb_q.pop_front();
            act = dut_vec();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL raster_cycle_%0d: got %h want %h", i, act, exp);
            end
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (de) de_hi++;
            if (frame_start) begin
                fs_n++;
                if (fs_at >= 0) fs_per = i - fs_at;
                fs_at = i;
            end
            if (exp[21:11] == 11'd0 && (exp[32:22] == 11'd0 || exp[32:22] == 11'd85 ||
                exp[32:22] == 11'd639 || exp[32:22] == 11'd700)) begin
                logic [11:0] want;
`ifdef VGA_TIMING_TEST_PATTERN_EN
                case (exp[32:22])
                    11'd85:  want = 12'h00F;
                    11'd639: want = 12'hFFF;
                    default: want = 12'h000;
                endcase
`else
                want = 12'h000;
`endif
                n_cmp++;
                if (rgb !== want) begin
                    n_bad++;
                    $display("FAIL rgb_at_x%0d: got %h want %h", exp[32:22], rgb, want);
                end
            end
            push_next();
        end
        n_cmp++;
        if (hs_lo !== HS * VT * 2) begin
            n_bad++;
            $display("FAIL hsync_low_total: got %0d want %0d", hs_lo, HS * VT * 2);
        end
        n_cmp++;
        if (vs_lo !== VS * HT * 2) begin
            n_bad++;
            $display("FAIL vsync_low_total: got %0d want %0d", vs_lo, VS * HT * 2);
        end
        n_cmp++;
        if (de_hi !== HA * VA * 2) begin
            n_bad++;
            $display("FAIL de_high_total: got %0d want %0d", de_hi, HA * VA * 2);
        end
        n_cmp++;
        if (fs_n !== 2 || fs_per !== HT * VT) begin
            n_bad++;
            $display("FAIL frame_start_count_period: got %0d/%0d want 2/%0d", fs_n, fs_per, HT * VT);
        end
    endtask

    task automatic test_drop_lock();
        logic [39:0] exp;
        int cyc;
        bit hit = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
            tick();
            exp = sb_q.pop_front();
            n_cmp++;
            if (dut_vec() !== exp) begin
                n_bad++;
                $display("FAIL pre_drop_cycle_%0d: got %h want %h", i, dut_vec(), exp);
            end
            if (exp[32:22] == 11'd300 && exp[21:11] == 11'd10) hit = 1'b1;
            push_next();
        end
        sb_q.delete();
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL drop_point_reached: got 0 want 1");
        end
        locked = 1'b0;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (dut_vec() !== RESET_VEC && cyc < 3);
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL drop_lock_idle: got %h want %h", dut_vec(), RESET_VEC);
        end
        repeat (4) tick();
        locked = 1'b1;
        wait_running(cyc);
        n_cmp++;
        if (cyc !== SET + 3) begin
            n_bad++;
            $display("FAIL relock_latency: got %0d cycles want %0d", cyc, SET + 3);
        end
        tick();
        n_cmp++;
        if (dut_vec() !== model(0, 0)) begin
            n_bad++;
            $display("FAIL relock_frame_start: got %h want %h", dut_vec(), model(0, 0));
        end
    endtask

    task automatic test_settle_glitch();
        int cyc;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        locked = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL settle_not_running: got %b want 0", running);
        end
        locked = 1'b0;
        tick();
        locked = 1'b1;
        wait_running(cyc);
        n_cmp++;
        if (cyc !== SET + 3) begin
            n_bad++;
            $display("FAIL settle_restart_latency: got %0d cycles want %0d", cyc, SET + 3);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_frames();
        test_drop_lock();
        test_settle_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
